// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit path.
package uart_pkg;

    // Serializer states; IDLE is the only state where the line is not in a frame.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Parity type select values.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous word FIFO. The pointers carry one extra wrap bit so that
// full and empty are distinct without a separate counter register.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // Flags, occupancy and pointer advance; a full FIFO refuses a push even
    // when a pop happens in the same cycle.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == (AW+1)'(FIFO_DEPTH));
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a serializer with its own
// baud divider, optional parity and one or two stop bits. Configuration is
// captured when a word is loaded, so mid-frame changes wait for the next frame.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DIV_WIDTH-1:0]          DIV,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    input  logic                          IN_VALID,
    input  logic [DATA_WIDTH-1:0]         IN_DATA,
    output logic                          IN_READY,
    output logic                          TX_OUT,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    import uart_pkg::*;

    localparam int BW = $clog2(DATA_WIDTH);

    tx_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]  baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  load;
    logic                  bit_end;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                        input logic typ);
        return (^d) ^ (typ == PAR_ODD);
    endfunction

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (IN_VALID),
        .push_data (IN_DATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (FIFO_COUNT)
    );

    assign IN_READY = ~fifo_full;
    assign TX_OUT   = tx_q;
    assign BUSY     = busy_q;

    // Frame sequencing: bit timing, bit counting, shifting and word loads.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        bit_end  = (baud_q == div_q);

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + DIV_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                load = ~fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DATA_WIDTH-1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading pops the FIFO and snapshots the word and line settings.
        if (load) begin
            fifo_pop = 1'b1;
            state_d  = START;
            baud_d   = '0;
            bit_d    = '0;
            stop_d   = 1'b0;
            shreg_d  = fifo_rdata;
            div_d    = DIV;
            par_en_d = PAR_EN;
            stop2_d  = STOP2;
            par_d    = parity_bit(fifo_rdata, PAR_TYP);
        end
    end

    // Line level and busy flag are decoded from the next state so both
    // leave the block straight from flops.
    always_comb begin
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // Control state; reset aborts any frame and parks the line high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Frame data and captured settings; only meaningful once a word is loaded.
    always_ff @(posedge CLK) begin
        shreg_q  <= shreg_d;
        div_q    <= div_d;
        par_en_q <= par_en_d;
        stop2_q  <= stop2_d;
        par_q    <= par_d;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised next-generation UART transmit path: buffered, configurable-width serializer with an internal baud divider, optional parity and 1 or 2 stop bits. A synchronous FIFO sits in front of the shift engine, so bursts of parallel words are absorbed and sent back-to-back without idle gaps. It replaces the fixed 8-bit, unbuffered transmitter in the UART top and drives the serial TX line directly.

## Interface
- DATA_WIDTH, default 8: data bits per frame; legal 5..16.
- FIFO_DEPTH, default 8: word entries; power of two, ≥2.
- DIV_WIDTH, default 16: width of the baud divider input.
- CLK  in  1  single clock for the whole block.
- RST  in  1  reset; synchronous and active-low.
- DIV  in  DIV_WIDTH  clocks per bit minus one; 0 is legal, giving 1 clock per bit.
- PAR_EN  in  1  1 = parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- IN_VALID  in  1  write request.
- IN_DATA  in  DATA_WIDTH  word to queue.
- IN_READY  out  1  FIFO can accept a word; high when FIFO_COUNT < FIFO_DEPTH.
- TX_OUT  out  1  serial line; idles high.
- BUSY  out  1  a frame is on the line (state ≠ IDLE).
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  words currently queued; excludes the word in the shifter.

## Operation
- Write handshake: a word is accepted in any cycle where IN_VALID & IN_READY. IN_VALID while IN_READY is low has no effect; the source holds the word.
- A full FIFO keeps IN_READY low even when a pop occurs in the same cycle. There is no pass-through.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the word and latch the word, DIV, PAR_EN, PAR_TYP and STOP2. Go to START.
  - START → DATA → (PARITY if PAR_EN) → STOP.
  - From STOP: after the last stop bit, go to START if the FIFO is non-empty (popping in that cycle), otherwise go to IDLE.
- Bit period: a baud counter counts 0..DIV_latched. Each bit lasts exactly DIV+1 cycles.
- Bit order:
  - START drives 0.
  - DATA sends LSB first; a bit counter runs 0..DATA_WIDTH-1.
  - PARITY sends ^data for even, ~^data for odd.
  - STOP drives 1 for 1 or 2 bit periods.
- Changes to the configuration inputs during a frame take effect at the next frame load only.

## Timing
- Reset values: TX_OUT=1, BUSY=0, IN_READY=1, FIFO_COUNT=0. FSM, baud counter and bit counter all cleared.
- Latency, write into an idle, empty block:
  - word accepted at cycle t;
  - FIFO_COUNT=1 and pop at t+1;
  - TX_OUT=0 and BUSY=1 from t+2.
- TX_OUT and BUSY are registered outputs.
- Frame length = (DIV+1)·(1+DATA_WIDTH+PAR_EN+1+STOP2) cycles. Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- Capacity: FIFO_DEPTH queued words plus 1 in the shifter.
- Reset during a frame: the frame aborts. In the cycle after RST is sampled low, TX_OUT=1 and the FIFO is flushed. No partial frame resumes after release.
- Simultaneous push and pop with the FIFO neither full nor empty: FIFO_COUNT is unchanged.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- One sub-module: uart_sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH). It has push/pop ports, full/empty flags and count, and wraps its pointers with one extra bit so full and empty are distinct.
- The FSM, baud counter, bit counter and shifter live in uart_tx_fifo.

## Test plan
- Reset: RST=0 for 3 cycles with IN_VALID=1 → TX_OUT=1, BUSY=0, IN_READY=1, FIFO_COUNT=0; nothing is accepted.
- Single frame, DIV=3, PAR_EN=0, STOP2=0, write 0xA5 at t:
  - start bit low t+2..t+5;
  - data bits 1,0,1,0,0,1,0,1, 4 cycles each;
  - stop bit high t+38..t+41;
  - BUSY=0 at t+42.
- Parity, DIV=0, word 0x03: PAR_TYP=0 → parity bit 0; PAR_TYP=1 → parity bit 1. Each frame is exactly 11 cycles.
- Overflow, FIFO_DEPTH=8, DIV=15, IN_VALID held with 10 distinct words:
  - IN_READY falls after 9 accepted words;
  - the 10th word is accepted once the first frame ends;
  - all 10 frames are sent in order with no idle gaps.
- DATA_WIDTH=5 instance, DIV=0, STOP2=1, two words queued: 16 contiguous cycles, with TX_OUT high exactly 2 cycles between the frames.
- Reset mid-frame: RST=0 during data bit 3 with 3 words queued → next cycle TX_OUT=1, FIFO_COUNT=0, BUSY=0; no frame after release.
